// File: rtl/pwm_multi_shadow.sv
// CH-channel PWM sharing one period counter; period/duty/frac are shadowed and applied only at period
// boundaries. Define PWM_DITHER_EN to add per-channel sigma-delta fractional dither (port list unchanged).
module pwm_multi_shadow #(
  parameter int CH         = 2,
  parameter int CNT_W      = 16,
  parameter int PERIOD_RST = 65535,
  parameter int FRAC_W     = 8
) (
  input  logic                 CLK_SYS,
  input  logic                 CLK_RST,
  input  logic [CNT_W-1:0]     PWM_Period,
  input  logic [CH*CNT_W-1:0]  PWM_Duty,
  input  logic [CH*FRAC_W-1:0] PWM_Frac,
  input  logic                 PWM_Load,
  input  logic [CH-1:0]        PWM_En,
  output logic [CH-1:0]        PWM_Out,
  output logic                 PWM_Sync,
  output logic                 PWM_Pending
);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] period_reg;
  logic [CNT_W-1:0] period_shadow_reg;
  logic             pending_reg;
  logic             sync_reg;
  logic [CNT_W-1:0] cnt_last;
  logic             boundary;
  logic             commit;

  // Periods below 2 behave as 2, so the last count is never below 1.
  assign cnt_last = (period_reg < CNT_W'(2)) ? CNT_W'(1) : period_reg - CNT_W'(1);
  assign boundary = (cnt_reg == cnt_last);
  assign commit   = boundary && pending_reg;

  always_ff @(posedge CLK_SYS) begin
    if (CLK_RST) begin
      cnt_reg           <= '0;
      period_reg        <= CNT_W'(PERIOD_RST);
      period_shadow_reg <= '0;
      pending_reg       <= 1'b0;
      sync_reg          <= 1'b0;
    end else begin
      cnt_reg  <= boundary ? '0 : cnt_reg + CNT_W'(1);
      sync_reg <= (cnt_reg == '0);
      if (PWM_Load) begin
        period_shadow_reg <= PWM_Period;
      end
      if (commit) begin
        period_reg <= period_shadow_reg;
      end
      // A load on the commit edge re-arms pending for the following boundary.
      if (PWM_Load) begin
        pending_reg <= 1'b1;
      end else if (commit) begin
        pending_reg <= 1'b0;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_ch
      logic [CNT_W-1:0] duty_shadow_reg;
      logic [CNT_W-1:0] duty_reg;
      logic [CNT_W:0]   duty_eff;
      logic             out_reg;

`ifdef PWM_DITHER_EN
      logic [FRAC_W-1:0] frac_shadow_reg;
      logic [FRAC_W-1:0] frac_reg;
      logic [FRAC_W-1:0] acc_reg;
      logic              carry_reg;
      logic [FRAC_W:0]   acc_sum;

      assign acc_sum = {1'b0, acc_reg} + {1'b0, frac_reg};
      // cnt never reaches P, so D+carry above P already reads as "high all period".
      assign duty_eff = {1'b0, duty_reg} + {{CNT_W{1'b0}}, carry_reg};

      always_ff @(posedge CLK_SYS) begin
        if (CLK_RST) begin
          frac_shadow_reg <= '0;
          frac_reg        <= '0;
          acc_reg         <= '0;
          carry_reg       <= 1'b0;
        end else begin
          if (PWM_Load) begin
            frac_shadow_reg <= PWM_Frac[gi*FRAC_W +: FRAC_W];
          end
          if (boundary) begin
            acc_reg   <= acc_sum[FRAC_W-1:0];
            carry_reg <= acc_sum[FRAC_W];
          end
          if (commit) begin
            frac_reg <= frac_shadow_reg;
          end
        end
      end
`else
      assign duty_eff = {1'b0, duty_reg};
`endif

      always_ff @(posedge CLK_SYS) begin
        if (CLK_RST) begin
          duty_shadow_reg <= '0;
          duty_reg        <= '0;
          out_reg         <= 1'b0;
        end else begin
          if (PWM_Load) begin
            duty_shadow_reg <= PWM_Duty[gi*CNT_W +: CNT_W];
          end
          if (commit) begin
            duty_reg <= duty_shadow_reg;
          end
          out_reg <= PWM_En[gi] && ({1'b0, cnt_reg} < duty_eff);
        end
      end

      assign PWM_Out[gi] = out_reg;
    end
  endgenerate

`ifndef PWM_DITHER_EN
  logic unused_frac;
  assign unused_frac = ^PWM_Frac;
`endif

  assign PWM_Sync    = sync_reg;
  assign PWM_Pending = pending_reg;

endmodule
